// File: rtl/lc3_control_fsm.sv
// LC-3 control sequencer for the operate subset, LEA, BR and TRAP x25: owns IR/NZP and
// Moore-decodes datapath controls from the registered state and IR.
module lc3_control_fsm #(
  parameter int WAIT_LIMIT      = 15,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        i_CLK,
  input  logic        i_Reset,
  input  logic        i_Run,
  input  logic        i_MemR,
  input  logic [15:0] i_bus,
  output logic        o_MemEn,
  output logic        o_LD_MAR,
  output logic        o_LD_MDR,
  output logic        o_LD_IR,
  output logic        o_LD_PC,
  output logic        o_LD_REG,
  output logic        o_LD_CC,
  output logic        o_GatePC,
  output logic        o_GateMDR,
  output logic        o_GateALU,
  output logic        o_GateMARMUX,
  output logic [1:0]  o_PCMUX,
  output logic        o_ADDR1MUX,
  output logic [1:0]  o_ADDR2MUX,
  output logic        o_MARMUX,
  output logic [1:0]  o_ALUK,
  output logic [1:0]  o_SR1MUX,
  output logic [1:0]  o_DRMUX,
  output logic [15:0] o_IR,
  output logic [2:0]  o_NZP,
  output logic        o_Halted,
  output logic        o_Error,
  output logic [3:0]  o_State
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH_MAR = 4'd1,
    S_FETCH_MEM = 4'd2,
    S_FETCH_IR  = 4'd3,
    S_DECODE    = 4'd4,
    S_EXE_ALU   = 4'd5,
    S_EXE_LEA   = 4'd6,
    S_BR_TAKE   = 4'd7,
    S_HALT      = 4'd8,
    S_ERR       = 4'd9
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;
  localparam logic [7:0] WAIT_MAX = 8'(WAIT_LIMIT);

  state_t      state;
  state_t      state_nxt;
  state_t      next_instr;
  logic [15:0] ir;
  logic [2:0]  nzp;
  logic [7:0]  wait_cnt;
  logic [3:0]  opcode;
  logic        ben;

  assign opcode     = ir[15:12];
  assign ben        = |(ir[11:9] & nzp);
  assign next_instr = i_Run ? S_FETCH_MAR : S_IDLE;

  always_ff @(posedge i_CLK or negedge i_Reset) begin
    if (!i_Reset) begin
      state    <= S_IDLE;
      ir       <= 16'h0000;
      nzp      <= 3'b010;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (o_LD_IR) ir <= i_bus;
      if (o_LD_CC) begin
        if (i_bus[15])          nzp <= 3'b100;
        else if (i_bus == 16'h0) nzp <= 3'b010;
        else                    nzp <= 3'b001;
      end
      // Counter only runs while stalled on memory; any other cycle clears it.
      if (state == S_FETCH_MEM && !i_MemR) wait_cnt <= wait_cnt + 8'd1;
      else                                 wait_cnt <= 8'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (i_Run) state_nxt = S_FETCH_MAR;
      S_FETCH_MAR: state_nxt = S_FETCH_MEM;
      S_FETCH_MEM: begin
        if (i_MemR)                             state_nxt = S_FETCH_IR;
        else if (wait_cnt == WAIT_MAX - 8'd1)   state_nxt = S_ERR;
      end
      S_FETCH_IR:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: state_nxt = S_EXE_ALU;
          OP_LEA:                 state_nxt = S_EXE_LEA;
          OP_BR:                  state_nxt = ben ? S_BR_TAKE : next_instr;
          OP_TRAP: begin
            if (ir[7:0] == 8'h25)     state_nxt = S_HALT;
            else if (HALT_ON_ILLEGAL) state_nxt = S_HALT;
            else                      state_nxt = next_instr;
          end
          default:                state_nxt = HALT_ON_ILLEGAL ? S_HALT : next_instr;
        endcase
      end
      S_EXE_ALU, S_EXE_LEA, S_BR_TAKE: state_nxt = next_instr;
      S_HALT:      state_nxt = S_HALT;
      S_ERR:       state_nxt = S_ERR;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_MemEn      = 1'b0;
    o_LD_MAR     = 1'b0;
    o_LD_MDR     = 1'b0;
    o_LD_IR      = 1'b0;
    o_LD_PC      = 1'b0;
    o_LD_REG     = 1'b0;
    o_LD_CC      = 1'b0;
    o_GatePC     = 1'b0;
    o_GateMDR    = 1'b0;
    o_GateALU    = 1'b0;
    o_GateMARMUX = 1'b0;
    o_PCMUX      = 2'b00;
    o_ADDR1MUX   = 1'b0;
    o_ADDR2MUX   = 2'b00;
    o_MARMUX     = 1'b0;
    o_ALUK       = 2'b00;
    o_SR1MUX     = 2'b00;
    o_DRMUX      = 2'b00;
    case (state)
      S_FETCH_MAR: begin
        o_GatePC = 1'b1;
        o_LD_MAR = 1'b1;
        o_LD_PC  = 1'b1;
      end
      S_FETCH_MEM: begin
        o_MemEn  = 1'b1;
        o_LD_MDR = 1'b1;
      end
      S_FETCH_IR: begin
        o_GateMDR = 1'b1;
        o_LD_IR   = 1'b1;
      end
      S_EXE_ALU: begin
        o_GateALU = 1'b1;
        o_LD_REG  = 1'b1;
        o_LD_CC   = 1'b1;
        o_SR1MUX  = 2'b01;
        if (opcode == OP_AND)      o_ALUK = 2'b01;
        else if (opcode == OP_NOT) o_ALUK = 2'b10;
      end
      S_EXE_LEA: begin
        o_GateMARMUX = 1'b1;
        o_MARMUX     = 1'b1;
        o_ADDR2MUX   = 2'b10;
        o_LD_REG     = 1'b1;
      end
      S_BR_TAKE: begin
        o_LD_PC    = 1'b1;
        o_PCMUX    = 2'b10;
        o_ADDR2MUX = 2'b10;
      end
      default: ;
    endcase
  end

  assign o_IR     = ir;
  assign o_NZP    = nzp;
  assign o_Halted = (state == S_HALT);
  assign o_Error  = (state == S_ERR);
  assign o_State  = state;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Bench for lc3_control_fsm: two instances (short timeout / halt-on-illegal, and default
// timeout / illegal-as-NOP) share stimulus and are checked every cycle against a reference model.
module tb_lc3_control_fsm;

  localparam int S_IDLE = 0, S_FMAR = 1, S_FMEM = 2, S_FIR = 3, S_DEC = 4,
                 S_ALU = 5, S_LEA = 6, S_BR = 7, S_HALT = 8, S_ERR = 9;
  localparam int B_MEMEN = 22, B_LDMAR = 21, B_LDMDR = 20, B_LDIR = 19, B_LDPC = 18,
                 B_LDREG = 17, B_LDCC = 16, B_GPC = 15, B_GMDR = 14, B_GALU = 13,
                 B_GMARMUX = 12, B_MARMUX = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic memr = 1'b0;
  logic [15:0] bus = 16'h0;

  logic [1:0] memen, ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc;
  logic [1:0] g_pc, g_mdr, g_alu, g_marmux, addr1mux, marmux, halted, error;
  logic [1:0][1:0] pcmux, addr2mux, aluk, sr1mux, drmux;
  logic [1:0][15:0] ir_o;
  logic [1:0][2:0] nzp_o;
  logic [1:0][3:0] st_o;
  logic [22:0] dut_ctrl [2];

  int total = 0;
  int bad = 0;
  int mc;

  int          m_st  [2];
  logic [15:0] m_ir  [2];
  logic [2:0]  m_nzp [2];
  int          m_cnt [2];

  always #5 clk = ~clk;

  lc3_control_fsm #(.WAIT_LIMIT(4)) dut_a (
    .i_CLK(clk), .i_Reset(rst_n), .i_Run(run), .i_MemR(memr), .i_bus(bus),
    .o_MemEn(memen[0]), .o_LD_MAR(ld_mar[0]), .o_LD_MDR(ld_mdr[0]), .o_LD_IR(ld_ir[0]),
    .o_LD_PC(ld_pc[0]), .o_LD_REG(ld_reg[0]), .o_LD_CC(ld_cc[0]),
    .o_GatePC(g_pc[0]), .o_GateMDR(g_mdr[0]), .o_GateALU(g_alu[0]), .o_GateMARMUX(g_marmux[0]),
    .o_PCMUX(pcmux[0]), .o_ADDR1MUX(addr1mux[0]), .o_ADDR2MUX(addr2mux[0]), .o_MARMUX(marmux[0]),
    .o_ALUK(aluk[0]), .o_SR1MUX(sr1mux[0]), .o_DRMUX(drmux[0]),
    .o_IR(ir_o[0]), .o_NZP(nzp_o[0]), .o_Halted(halted[0]), .o_Error(error[0]), .o_State(st_o[0])
  );

  lc3_control_fsm #(.HALT_ON_ILLEGAL(1'b0)) dut_b (
    .i_CLK(clk), .i_Reset(rst_n), .i_Run(run), .i_MemR(memr), .i_bus(bus),
    .o_MemEn(memen[1]), .o_LD_MAR(ld_mar[1]), .o_LD_MDR(ld_mdr[1]), .o_LD_IR(ld_ir[1]),
    .o_LD_PC(ld_pc[1]), .o_LD_REG(ld_reg[1]), .o_LD_CC(ld_cc[1]),
    .o_GatePC(g_pc[1]), .o_GateMDR(g_mdr[1]), .o_GateALU(g_alu[1]), .o_GateMARMUX(g_marmux[1]),
    .o_PCMUX(pcmux[1]), .o_ADDR1MUX(addr1mux[1]), .o_ADDR2MUX(addr2mux[1]), .o_MARMUX(marmux[1]),
    .o_ALUK(aluk[1]), .o_SR1MUX(sr1mux[1]), .o_DRMUX(drmux[1]),
    .o_IR(ir_o[1]), .o_NZP(nzp_o[1]), .o_Halted(halted[1]), .o_Error(error[1]), .o_State(st_o[1])
  );

  always_comb begin
    for (int k = 0; k < 2; k++)
      dut_ctrl[k] = {memen[k], ld_mar[k], ld_mdr[k], ld_ir[k], ld_pc[k], ld_reg[k], ld_cc[k],
                     g_pc[k], g_mdr[k], g_alu[k], g_marmux[k], pcmux[k], addr1mux[k],
                     addr2mux[k], marmux[k], aluk[k], sr1mux[k], drmux[k]};
  end

  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15]) return 3'b100;
    if (v == 16'h0) return 3'b010;
    return 3'b001;
  endfunction

  // Expected control word: which loads/gates/selects each step of an instruction needs.
  function automatic logic [22:0] exp_ctrl(input int st, input logic [15:0] ir);
    logic [22:0] c;
    c = '0;
    case (st)
      S_FMAR: begin c[B_GPC] = 1'b1; c[B_LDMAR] = 1'b1; c[B_LDPC] = 1'b1; end
      S_FMEM: begin c[B_MEMEN] = 1'b1; c[B_LDMDR] = 1'b1; end
      S_FIR:  begin c[B_GMDR] = 1'b1; c[B_LDIR] = 1'b1; end
      S_ALU: begin
        c[B_GALU] = 1'b1; c[B_LDREG] = 1'b1; c[B_LDCC] = 1'b1; c[3:2] = 2'b01;
        if (ir[15:12] == 4'h5) c[5:4] = 2'b01;
        if (ir[15:12] == 4'h9) c[5:4] = 2'b10;
      end
      S_LEA: begin c[B_GMARMUX] = 1'b1; c[B_MARMUX] = 1'b1; c[8:7] = 2'b10; c[B_LDREG] = 1'b1; end
      S_BR:  begin c[B_LDPC] = 1'b1; c[11:10] = 2'b10; c[8:7] = 2'b10; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = S_IDLE; m_ir[k] = 16'h0; m_nzp[k] = 3'b010; m_cnt[k] = 0;
    end
  endtask

  // One rising edge of the reference: instance 0 times out after 4 stalls and halts on
  // unsupported opcodes; instance 1 times out after 15 and skips them.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int nx, lim, nxt_instr;
      bit hoi;
      logic [3:0] opc;
      lim = (k == 0) ? 4 : 15;
      hoi = (k == 0);
      opc = m_ir[k][15:12];
      nxt_instr = run ? S_FMAR : S_IDLE;
      nx = m_st[k];
      case (m_st[k])
        S_IDLE: nx = run ? S_FMAR : S_IDLE;
        S_FMAR: nx = S_FMEM;
        S_FMEM: if (memr) nx = S_FIR; else if (m_cnt[k] + 1 >= lim) nx = S_ERR;
        S_FIR:  nx = S_DEC;
        S_DEC: begin
          if (opc inside {4'h1, 4'h5, 4'h9})            nx = S_ALU;
          else if (opc == 4'hE)                         nx = S_LEA;
          else if (opc == 4'h0)                         nx = ((m_ir[k][11:9] & m_nzp[k]) != 3'b0) ? S_BR : nxt_instr;
          else if (opc == 4'hF && m_ir[k][7:0] == 8'h25) nx = S_HALT;
          else                                          nx = hoi ? S_HALT : nxt_instr;
        end
        S_ALU, S_LEA, S_BR: nx = nxt_instr;
        default: ;
      endcase
      m_cnt[k] = (m_st[k] == S_FMEM && !memr) ? m_cnt[k] + 1 : 0;
      if (m_st[k] == S_FIR) m_ir[k] = bus;
      if (m_st[k] == S_ALU) m_nzp[k] = nzp_of(bus);
      m_st[k] = nx;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("state%0d", k), 32'(st_o[k]), 32'(m_st[k]));
      chk($sformatf("ctrl%0d", k), 32'(dut_ctrl[k]), 32'(exp_ctrl(m_st[k], m_ir[k])));
      chk($sformatf("ir%0d", k), 32'(ir_o[k]), 32'(m_ir[k]));
      chk($sformatf("nzp%0d", k), 32'(nzp_o[k]), 32'(m_nzp[k]));
      chk($sformatf("flags%0d", k), {30'b0, halted[k], error[k]},
          {30'b0, m_st[k] == S_HALT, m_st[k] == S_ERR});
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  // From FETCH_MAR: fetch instr with nwait stalls; returns in DECODE. memcyc counts
  // FETCH_MEM cycles seen on instance 0 with the request raised.
  task automatic issue(input logic [15:0] instr, input int nwait, output int memcyc);
    memcyc = 0;
    bus = instr;
    memr = 1'b0;
    cycle();
    for (int i = 0; i < nwait; i++) begin
      if (st_o[0] == 4'd2 && memen[0]) memcyc++;
      cycle();
    end
    if (st_o[0] == 4'd2 && memen[0]) memcyc++;
    memr = 1'b1;
    cycle();
    cycle();
  endtask

  function automatic logic [15:0] rand_bus();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 15))
      0, 1:    r[15:12] = 4'h1;
      2, 3:    r[15:12] = 4'h5;
      4:       r[15:12] = 4'h9;
      5:       r[15:12] = 4'hE;
      6, 7, 8: r[15:12] = 4'h0;
      9:       r = 16'h0000;
      10:      r[15] = 1'b1;
      11:      r = 16'hF025;
      12:      r[15:12] = 4'hF;
      13:      r[15:12] = 4'hD;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    chk("rst_state", 32'(st_o[0]), 32'd0);
    chk("rst_nzp", 32'(nzp_o[0]), 32'b010);
    chk("rst_ctrl", 32'(dut_ctrl[0]), 32'd0);
    rst_n = 1'b1;
    cycle();
    chk("idle_hold", 32'(st_o[0]), 32'd0);

    // ADD, result zero
    run = 1'b1;
    cycle();
    chk("t1_fmar", 32'(st_o[0]), 32'd1);
    issue(16'h1261, 0, mc);
    chk("t1_memcyc", 32'(mc), 32'd1);
    chk("t1_decode", 32'(st_o[0]), 32'd4);
    chk("t1_ir", 32'(ir_o[0]), 32'h1261);
    bus = 16'h0000;
    cycle();
    chk("t1_alu", {24'b0, st_o[0], ld_reg[0], aluk[0], drmux[0]}, {24'b0, 4'd5, 1'b1, 2'b00, 2'b00});
    cycle();
    chk("t1_next", {28'b0, st_o[0]}, 32'd1);
    chk("t1_nzp", 32'(nzp_o[0]), 32'b010);

    // NOT, negative result
    issue(16'h927F, 0, mc);
    cycle();
    chk("t5_not_aluk", 32'(aluk[0]), 32'b10);
    bus = 16'h8000;
    cycle();
    chk("t5_nzp_neg", 32'(nzp_o[0]), 32'b100);

    // BR n taken, BR z not taken
    issue(16'h0805, 0, mc);
    cycle();
    chk("t3_br_take", {24'b0, st_o[0], ld_pc[0], pcmux[0]}, {24'b0, 4'd7, 1'b1, 2'b10});
    cycle();
    issue(16'h0405, 0, mc);
    chk("t3_dec_nopc", 32'(ld_pc[0]), 32'd0);
    cycle();
    chk("t3_not_taken", 32'(st_o[0]), 32'd1);

    // LEA and AND with positive result
    issue(16'hE1FF, 0, mc);
    cycle();
    chk("lea", {24'b0, st_o[0], g_marmux[0], ld_reg[0], ld_cc[0]}, {24'b0, 4'd6, 3'b110});
    cycle();
    issue(16'h5000, 0, mc);
    cycle();
    chk("and_aluk", 32'(aluk[0]), 32'b01);
    bus = 16'h0001;
    cycle();
    chk("and_nzp_pos", 32'(nzp_o[0]), 32'b001);

    // Run dropped mid-instruction: completes, then idles
    issue(16'h1000, 0, mc);
    run = 1'b0;
    cycle();
    chk("run_low_exec", 32'(st_o[0]), 32'd5);
    cycle();
    chk("run_low_idle", 32'(st_o[0]), 32'd0);

    // Memory stalls and timeouts
    run = 1'b1;
    cycle();
    issue(16'h1261, 3, mc);
    chk("t2_memcyc", 32'(mc), 32'd4);
    chk("t2_decode", 32'(st_o[0]), 32'd4);
    cycle();
    cycle();
    memr = 1'b0;
    cycle();
    for (int i = 0; i < 4; i++) cycle();
    chk("t2_a_err", {30'b0, error[0], st_o[0] == 4'd9}, 32'b11);
    chk("t2_b_wait", 32'(st_o[1]), 32'd2);
    for (int i = 0; i < 10; i++) begin
      run = (i % 2 == 0);
      cycle();
    end
    chk("t2_b_wait14", 32'(st_o[1]), 32'd2);
    cycle();
    chk("t2_b_err", {30'b0, error[1], st_o[1] == 4'd9}, 32'b11);
    chk("t2_a_sticky", 32'(st_o[0]), 32'd9);

    // Unsupported opcode, then HALT trap
    apply_reset();
    run = 1'b1;
    cycle();
    issue(16'hD000, 0, mc);
    cycle();
    chk("t5_illegal_halt", {30'b0, halted[0], st_o[0] == 4'd8}, 32'b11);
    chk("t5_illegal_nop", 32'(st_o[1]), 32'd1);
    issue(16'hF025, 0, mc);
    cycle();
    chk("t4_b_halt", 32'(st_o[1]), 32'd8);
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom);
      memr = 1'($urandom);
      bus = 16'($urandom);
      cycle();
      chk("t4_quiet", {9'b0, dut_ctrl[0], dut_ctrl[1]}, 32'd0);
      chk("t4_halted", 32'(halted), 32'b11);
    end
    apply_reset();
    chk("t4_reset", {28'b0, halted[0], halted[1], st_o[0] == 4'd0, st_o[1] == 4'd0}, 32'b0011);

    // Async reset between edges in FETCH_MEM
    run = 1'b1;
    cycle();
    issue(16'h1261, 0, mc);
    bus = 16'h8000;
    cycle();
    cycle();
    memr = 1'b0;
    cycle();
    cycle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_state", 32'(st_o[0]), 32'd0);
    chk("t6_memen", 32'(memen[0]), 32'd0);
    chk("t6_nzp", 32'(nzp_o[0]), 32'b010);
    chk("t6_ir", 32'(ir_o[0]), 32'd0);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Randomized traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      run  = ($urandom_range(0, 9) != 0);
      memr = ($urandom_range(0, 3) != 0);
      bus  = rand_bus();
      cycle();
      if ((m_st[0] >= S_HALT && m_st[1] >= S_HALT) || $urandom_range(0, 255) == 0)
        apply_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
